// File: rtl/rgb_channel_scheduler_if.sv
// Bus bundle between the RGB channel scheduler and its surroundings:
// pixel input stream, shared channel unit link, result output and status.
// master: the scheduler side. slave: the environment (stream, unit, sink).
interface rgb_channel_scheduler_if;
    localparam int unsigned CH_W  = 8;
    localparam int unsigned RES_W = 9;
    localparam int unsigned CNT_W = 16;

    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_r;
    logic [CH_W-1:0]  in_g;
    logic [CH_W-1:0]  in_b;
    logic [CH_W-1:0]  ch_a;
    logic [CH_W-1:0]  ch_b;
    logic [CH_W-1:0]  ch_c;
    logic [1:0]       mux_sel;
    logic             unit_in_valid;
    logic             unit_out_valid;
    logic [RES_W-1:0] unit_result;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_r;
    logic [RES_W-1:0] out_g;
    logic [RES_W-1:0] out_b;
    logic             err;
    logic [CNT_W-1:0] pix_count;

    modport master (
        input  in_valid, in_r, in_g, in_b, unit_out_valid, unit_result, out_ready,
        output in_ready, ch_a, ch_b, ch_c, mux_sel, unit_in_valid,
               out_valid, out_r, out_g, out_b, err, pix_count
    );

    modport slave (
        output in_valid, in_r, in_g, in_b, unit_out_valid, unit_result, out_ready,
        input  in_ready, ch_a, ch_b, ch_c, mux_sel, unit_in_valid,
               out_valid, out_r, out_g, out_b, err, pix_count
    );
endinterface

// File: rtl/rgb_channel_scheduler.sv
// Time-multiplexes one RGB pixel through a single shared channel unit:
// latch pixel, issue R/G/B on consecutive cycles, collect three in-order
// results, present them as one triple.
// Optional feature macro: RGB_CH_SCHED_PIX_CNT_EN enables the completed-pixel
// counter on pix_count; when undefined pix_count is tied to zero.
module rgb_channel_scheduler (
    input  logic                    clk,
    input  logic                    rst_n,
    rgb_channel_scheduler_if.master bus
);
    localparam int unsigned CH_W  = 8;
    localparam int unsigned RES_W = 9;
    localparam int unsigned CNT_W = 16;
    localparam logic [1:0]  SEL_IDLE = 2'b11;
    localparam logic [1:0]  CNT_FULL = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t           state_q,     state_d;
    logic [1:0]       iss_cnt_q,   iss_cnt_d;
    logic [1:0]       col_cnt_q,   col_cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic [CH_W-1:0]  ch_a_q,      ch_a_d;
    logic [CH_W-1:0]  ch_b_q,      ch_b_d;
    logic [CH_W-1:0]  ch_c_q,      ch_c_d;
    logic [1:0]       mux_sel_q,   mux_sel_d;
    logic             uiv_q,       uiv_d;
    logic             out_valid_q, out_valid_d;
    logic [RES_W-1:0] out_r_q,     out_r_d;
    logic [RES_W-1:0] out_g_q,     out_g_d;
    logic [RES_W-1:0] out_b_q,     out_b_d;
    logic             err_q,       err_d;
`ifdef RGB_CH_SCHED_PIX_CNT_EN
    logic [CNT_W-1:0] pix_cnt_q,   pix_cnt_d;
`endif

    // Next-state, collector and output register computation
    always_comb begin
        state_d     = state_q;
        iss_cnt_d   = iss_cnt_q;
        col_cnt_d   = col_cnt_q;
        in_ready_d  = in_ready_q;
        ch_a_d      = ch_a_q;
        ch_b_d      = ch_b_q;
        ch_c_d      = ch_c_q;
        mux_sel_d   = mux_sel_q;
        uiv_d       = uiv_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_g_d     = out_g_q;
        out_b_d     = out_b_q;
        err_d       = err_q;
`ifdef RGB_CH_SCHED_PIX_CNT_EN
        pix_cnt_d   = pix_cnt_q;
`endif

        // Collector runs alongside issue so results can land while still issuing
        if (bus.unit_out_valid) begin
            if ((state_q == ISSUE || state_q == WAIT) && col_cnt_q != CNT_FULL) begin
                case (col_cnt_q)
                    2'd0:    out_r_d = bus.unit_result;
                    2'd1:    out_g_d = bus.unit_result;
                    default: out_b_d = bus.unit_result;
                endcase
                col_cnt_d = col_cnt_q + 2'd1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    ch_a_d     = bus.in_r;
                    ch_b_d     = bus.in_g;
                    ch_c_d     = bus.in_b;
                    iss_cnt_d  = 2'd0;
                    col_cnt_d  = 2'd0;
                    mux_sel_d  = 2'd0;
                    uiv_d      = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (iss_cnt_q == 2'd2) begin
                    mux_sel_d = SEL_IDLE;
                    uiv_d     = 1'b0;
                    if (col_cnt_d == CNT_FULL) begin
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    iss_cnt_d = iss_cnt_q + 2'd1;
                    mux_sel_d = iss_cnt_q + 2'd1;
                end
            end
            WAIT: begin
                if (col_cnt_d == CNT_FULL) begin
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
`ifdef RGB_CH_SCHED_PIX_CNT_EN
                    pix_cnt_d   = pix_cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iss_cnt_q   <= 2'd0;
            col_cnt_q   <= 2'd0;
            in_ready_q  <= 1'b1;
            ch_a_q      <= '0;
            ch_b_q      <= '0;
            ch_c_q      <= '0;
            mux_sel_q   <= SEL_IDLE;
            uiv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
            err_q       <= 1'b0;
`ifdef RGB_CH_SCHED_PIX_CNT_EN
            pix_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            iss_cnt_q   <= iss_cnt_d;
            col_cnt_q   <= col_cnt_d;
            in_ready_q  <= in_ready_d;
            ch_a_q      <= ch_a_d;
            ch_b_q      <= ch_b_d;
            ch_c_q      <= ch_c_d;
            mux_sel_q   <= mux_sel_d;
            uiv_q       <= uiv_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
            err_q       <= err_d;
`ifdef RGB_CH_SCHED_PIX_CNT_EN
            pix_cnt_q   <= pix_cnt_d;
`endif
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.ch_a          = ch_a_q;
    assign bus.ch_b          = ch_b_q;
    assign bus.ch_c          = ch_c_q;
    assign bus.mux_sel       = mux_sel_q;
    assign bus.unit_in_valid = uiv_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_r         = out_r_q;
    assign bus.out_g         = out_g_q;
    assign bus.out_b         = out_b_q;
    assign bus.err           = err_q;
`ifdef RGB_CH_SCHED_PIX_CNT_EN
    assign bus.pix_count     = pix_cnt_q;
`else
    assign bus.pix_count     = '0;
`endif

endmodule

// File: doc/rgb_channel_scheduler.md
# rgb_channel_scheduler

Time-multiplexes one RGB pixel through a single shared per-channel processing unit. The scheduler latches a pixel, drives the 3-input 8-bit channel mux select through red, green, blue on consecutive cycles, and collects the unit's three in-order 9-bit results. It then presents them as one output triple. It sits between the pixel stream and the shared channel unit, so one unit replaces three parallel copies.

## Interface
- `UNIT_LAT`, default 2: fixed unit latency in cycles, from `unit_in_valid` to `unit_out_valid`; range 1–8. Used only by the bench; the RTL counts `unit_out_valid` pulses.
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `in_valid` in 1: pixel offered.
- `in_ready` out 1: the scheduler can accept a pixel.
- `in_r`, `in_g`, `in_b` in 8 each: pixel channels.
- `ch_a`, `ch_b`, `ch_c` out 8 each: latched R, G, B, wired to the mux inputs a, b, c.
- `mux_sel` out 2: mux select; 2'b11 means idle, and the mux then outputs 0.
- `unit_in_valid` out 1: the mux output is a valid unit operand this cycle.
- `unit_out_valid` in 1: unit result valid.
- `unit_result` in 9: unit result.
- `out_valid` out 1: result triple valid.
- `out_ready` in 1: the downstream stage accepts the triple.
- `out_r`, `out_g`, `out_b` out 9 each: collected results.
- `err` out 1: sticky protocol error.
- `pix_count` out 16: count of completed pixels (see Configuration).

## Operation
- FSM states are IDLE, ISSUE, WAIT and OUT. All outputs are registered.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `in_r/g/b` into `ch_a/b/c`, clear the issue counter and collect counter, and go to ISSUE.
- ISSUE:
  - Lasts 3 cycles; `unit_in_valid`=1.
  - `mux_sel` = 00, 01, 10 on successive cycles.
  - After sel=10, go to WAIT. If the third result has already been collected, go directly to OUT.
- WAIT:
  - `unit_in_valid`=0 and `mux_sel`=11.
  - When the collect count reaches 3, go to OUT.
- Collector:
  - Active in both ISSUE and WAIT.
  - On each `unit_out_valid`, write `unit_result` into `out_r`, `out_g`, `out_b` in that order, selected by a 2-bit collect counter (0 → r, 1 → g, 2 → b).
- OUT:
  - `out_valid`=1; data is held stable until `out_ready`.
  - On handshake, go to IDLE and increment `pix_count`.
- Error cases (each sets `err`=1, and the event is otherwise ignored):
  - `unit_out_valid` in IDLE or OUT.
  - `unit_out_valid` while the collect count is already 3.
- `err` clears only on reset.
- `in_ready` is 0 in every state other than IDLE; there is no input skid.
- `ch_a/b/c` are stable from accept until the next accept.

## Timing
- Reset values:
  - `in_ready`=1, `mux_sel`=2'b11, and every other output is 0.
  - FSM=IDLE, counters=0.
- Accept on edge t. Then:
  - `unit_in_valid`=1 with sel 00/01/10 during cycles t+1, t+2, t+3.
  - `mux_sel`=11 from t+4 onward.
- With unit latency L, the results arrive at t+1+L, t+2+L and t+3+L.
- `out_valid` rises at t+4+L.
- If `out_ready` is already high, the handshake completes at t+4+L:
  - `in_ready`=1 at t+5+L.
  - The minimum accept-to-accept interval is 5+L cycles.
- L=1: results overlap ISSUE. The collector must capture a result in the same cycle as an issue.
- Downstream stall:
  - `out_valid`, `out_r/g/b` and `pix_count` are unchanged until the `out_ready` cycle.
  - `in_valid` is ignored during the stall.
- Reset mid-operation:
  - `rst_n`=0 on any edge returns the FSM to IDLE and all outputs to reset values.
  - Partially collected results are discarded.
  - The unit is not flushed. Results that arrive after reset count as errors; the bench must flush the unit before checking `err`.
- `pix_count` wraps from 16'hFFFF to 0.

## Configuration
- `RGB_CH_SCHED_PIX_CNT_EN`:
  - When defined, `pix_count` increments by 1 on each completed output handshake and wraps at 16 bits.
  - When undefined, `pix_count` is tied to 16'h0000 and the counter logic is not synthesized. The port is still present, so the top-level stays unchanged.

## Test plan
- Single pixel, L=2, `out_ready`=1: input (R,G,B)=(8'h10, 8'h20, 8'h30) accepted at t; unit returns input+1 → `mux_sel` 00/01/10 at t+1..t+3; `out_r/g/b`=9'h011/9'h021/9'h031 with `out_valid` at t+6; `in_ready` at t+7.
- L=1 overlap: input (8'hFF, 8'h00, 8'h80); unit returns input×2 → `out_r/g/b`=9'h1FE/9'h000/9'h100; `out_valid` at t+5; `err`=0.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid`, with `in_valid`=1 throughout → outputs stable, `in_ready`=0 throughout, then exactly one handshake; `pix_count` 0→1 (macro defined).
- Spurious result: pulse `unit_out_valid` in IDLE → `err`=1 and stays 1; the next pixel still completes correctly.
- Reset mid-operation: assert `rst_n`=0 one cycle after sel=01 → next cycle `mux_sel`=11, `unit_in_valid`=0, `out_valid`=0, `in_ready`=1; after the unit is flushed, a new pixel completes normally.
- Wrap (macro defined): complete 65536 pixels → `pix_count`=16'h0000. With the macro undefined, `pix_count` stays 0 throughout.
